// File: rtl/id_ex_pkg.sv
// id_ex_pkg: shared control-bit indices, opcode constants and decode helpers for the ID/EX stage.
package id_ex_pkg;
  localparam int CTRL_W        = 10;
  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMREAD  = 1;
  localparam int CTRL_MEMWRITE = 2;
  localparam int CTRL_MEMTOREG = 3;
  localparam int CTRL_ALUSRC   = 4;
  localparam int CTRL_REGDST   = 5;
  localparam int CTRL_ALUOP_LO = 6;
  localparam int CTRL_ALUOP_HI = 9;
  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_ANDI  = 6'd12;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_XORI  = 6'd14;
  function automatic logic uses_rt(input logic [5:0] op);
    return op inside {OP_RTYPE, OP_BEQ, OP_BNE, OP_SW};
  endfunction
  function automatic logic zero_ext(input logic [5:0] op);
    return op inside {OP_ANDI, OP_ORI, OP_XORI};
  endfunction
endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// hazard_detect: load-use stall when the load in EX targets a register the decode instruction reads.
module hazard_detect
  import id_ex_pkg::*;
(
  input  logic       ex_mem_read_i,
  input  logic [4:0] ex_rt_i,
  input  logic [5:0] op_i,
  input  logic [4:0] rs_i,
  input  logic [4:0] rt_i,
  input  logic       flush_i,
  output logic       stall_o
);
  logic hazard;
  assign hazard  = ex_mem_read_i && ex_rt_i != 5'd0 &&
                   (ex_rt_i == rs_i || (uses_rt(op_i) && ex_rt_i == rt_i));
  // a flushed decode instruction is dead, so it never needs to wait
  assign stall_o = hazard && !flush_i;
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: decode-to-execute pipeline register with load-use bubbles, branch flush
// and saturating stall/flush counters.
module id_ex_stage
  import id_ex_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = id_ex_pkg::CTRL_W,
  parameter int CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [31:0]       IF_ID_Instr,
  input  logic [DATA_W-1:0] IF_ID_PCPlus4,
  input  logic [DATA_W-1:0] ReadData1,
  input  logic [DATA_W-1:0] ReadData2,
  input  logic [CTRL_W-1:0] ID_Ctrl,
  input  logic              Flush,
  output logic              Stall,
  output logic [CTRL_W-1:0] EX_Ctrl,
  output logic [DATA_W-1:0] EX_ReadData1,
  output logic [DATA_W-1:0] EX_ReadData2,
  output logic [DATA_W-1:0] EX_Imm,
  output logic [DATA_W-1:0] EX_PCPlus4,
  output logic [4:0]        EX_Rs,
  output logic [4:0]        EX_Rt,
  output logic [4:0]        EX_Rd,
  output logic [CNT_W-1:0]  StallCount,
  output logic [CNT_W-1:0]  FlushCount
);
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] rd1_q, rd2_q, imm_q, pc_q, imm_d;
  logic [4:0]        rs_q, rt_q, rd_q;
  logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q;
  logic [5:0]        op;
  assign op = IF_ID_Instr[31:26];
  hazard_detect u_hazard (
    .ex_mem_read_i(ctrl_q[CTRL_MEMREAD]),
    .ex_rt_i      (rt_q),
    .op_i         (op),
    .rs_i         (IF_ID_Instr[25:21]),
    .rt_i         (IF_ID_Instr[20:16]),
    .flush_i      (Flush),
    .stall_o      (Stall)
  );
  always_comb begin
    imm_d  = zero_ext(op) ? {{(DATA_W-16){1'b0}}, IF_ID_Instr[15:0]}
                          : {{(DATA_W-16){IF_ID_Instr[15]}}, IF_ID_Instr[15:0]};
    ctrl_d = (Flush || Stall) ? '0 : ID_Ctrl;
  end
  // data/index fields load even for a bubble; they are ignored while ctrl is zero
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      ctrl_q <= '0;
      rd1_q  <= '0;
      rd2_q  <= '0;
      imm_q  <= '0;
      pc_q   <= '0;
      rs_q   <= '0;
      rt_q   <= '0;
      rd_q   <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      rd1_q  <= ReadData1;
      rd2_q  <= ReadData2;
      imm_q  <= imm_d;
      pc_q   <= IF_ID_PCPlus4;
      rs_q   <= IF_ID_Instr[25:21];
      rt_q   <= IF_ID_Instr[20:16];
      rd_q   <= IF_ID_Instr[15:11];
    end
  end
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (Flush && !(&flush_cnt_q)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      if (Stall && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end
  assign EX_Ctrl      = ctrl_q;
  assign EX_ReadData1 = rd1_q;
  assign EX_ReadData2 = rd2_q;
  assign EX_Imm       = imm_q;
  assign EX_PCPlus4   = pc_q;
  assign EX_Rs        = rs_q;
  assign EX_Rt        = rt_q;
  assign EX_Rd        = rd_q;
  assign StallCount   = stall_cnt_q;
  assign FlushCount   = flush_cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed plus randomized check of id_ex_stage against a behavioural model;
// a second instance with 2-bit counters exercises saturation.
module tb_id_ex_stage;
  logic        clk, rst_n, flush;
  logic [31:0] instr, pc, rd1, rd2;
  logic [9:0]  id_ctrl;
  logic        stall, stall2;
  logic [9:0]  ex_ctrl, ex_ctrl2;
  logic [31:0] ex_r1, ex_r2, ex_imm, ex_pc, ex_r1_2, ex_r2_2, ex_imm2, ex_pc2;
  logic [4:0]  ex_rs, ex_rt, ex_rd, ex_rs2, ex_rt2, ex_rd2;
  logic [15:0] scnt, fcnt;
  logic [1:0]  scnt2, fcnt2;

  id_ex_stage dut (
    .Clk(clk), .Rst_n(rst_n), .IF_ID_Instr(instr), .IF_ID_PCPlus4(pc),
    .ReadData1(rd1), .ReadData2(rd2), .ID_Ctrl(id_ctrl), .Flush(flush),
    .Stall(stall), .EX_Ctrl(ex_ctrl), .EX_ReadData1(ex_r1), .EX_ReadData2(ex_r2),
    .EX_Imm(ex_imm), .EX_PCPlus4(ex_pc), .EX_Rs(ex_rs), .EX_Rt(ex_rt), .EX_Rd(ex_rd),
    .StallCount(scnt), .FlushCount(fcnt)
  );
  id_ex_stage #(.CNT_W(2)) dut2 (
    .Clk(clk), .Rst_n(rst_n), .IF_ID_Instr(instr), .IF_ID_PCPlus4(pc),
    .ReadData1(rd1), .ReadData2(rd2), .ID_Ctrl(id_ctrl), .Flush(flush),
    .Stall(stall2), .EX_Ctrl(ex_ctrl2), .EX_ReadData1(ex_r1_2), .EX_ReadData2(ex_r2_2),
    .EX_Imm(ex_imm2), .EX_PCPlus4(ex_pc2), .EX_Rs(ex_rs2), .EX_Rt(ex_rt2), .EX_Rd(ex_rd2),
    .StallCount(scnt2), .FlushCount(fcnt2)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic [9:0]  m_ctrl;
  logic [31:0] m_r1, m_r2, m_imm, m_pc;
  logic [4:0]  m_rs, m_rt, m_rd;
  logic        m_dc;
  int          sc, fc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_stall();
    logic [5:0] op;
    logic       rd_rt;
    op = instr[31:26];
    rd_rt = (op == 0 || op == 4 || op == 5 || op == 43);
    return !flush && m_ctrl[1] && m_rt != 0 &&
           (m_rt == instr[25:21] || (rd_rt && m_rt == instr[20:16]));
  endfunction

  function automatic logic [31:0] exp_imm(input logic [31:0] ins);
    int op;
    op = int'(ins[31:26]);
    if (op == 12 || op == 13 || op == 14) return ins & 32'h0000_FFFF;
    return ins[15] ? (ins & 32'h0000_FFFF) | 32'hFFFF_0000 : ins & 32'h0000_FFFF;
  endfunction

  task automatic check_all();
    chk("stall", stall, exp_stall());
    chk("stall_w2", stall2, exp_stall());
    chk("ex_ctrl", ex_ctrl, m_ctrl);
    chk("ex_ctrl_w2", ex_ctrl2, m_ctrl);
    chk("stall_cnt", scnt, sc > 65535 ? 65535 : sc);
    chk("flush_cnt", fcnt, fc > 65535 ? 65535 : fc);
    chk("stall_cnt_w2", scnt2, sc > 3 ? 3 : sc);
    chk("flush_cnt_w2", fcnt2, fc > 3 ? 3 : fc);
    chk("no_x", $isunknown({ex_r1, ex_r2, ex_imm, ex_pc, ex_rs, ex_rt, ex_rd,
                            ex_r1_2, ex_r2_2, ex_imm2, ex_pc2, ex_rs2, ex_rt2, ex_rd2}), 0);
    if (!m_dc) begin
      chk("ex_rd1", ex_r1, m_r1);
      chk("ex_rd2", ex_r2, m_r2);
      chk("ex_imm", ex_imm, m_imm);
      chk("ex_pc", ex_pc, m_pc);
      chk("ex_rs", ex_rs, m_rs);
      chk("ex_rt", ex_rt, m_rt);
      chk("ex_rd", ex_rd, m_rd);
    end
  endtask

  task automatic step();
    logic st;
    st = exp_stall();
    if (!rst_n) begin
      m_ctrl = 0; m_r1 = 0; m_r2 = 0; m_imm = 0; m_pc = 0;
      m_rs = 0; m_rt = 0; m_rd = 0; m_dc = 0; sc = 0; fc = 0;
    end else begin
      m_r1 = rd1; m_r2 = rd2; m_imm = exp_imm(instr); m_pc = pc;
      m_rs = instr[25:21]; m_rt = instr[20:16]; m_rd = instr[15:11];
      if (flush) begin m_ctrl = 0; m_dc = 1; fc++; end
      else if (st) begin m_ctrl = 0; m_dc = 1; sc++; end
      else begin m_ctrl = id_ctrl; m_dc = 0; end
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  localparam logic [31:0] ADD  = {6'd0, 5'd8, 5'd10, 5'd9, 5'd0, 6'h20};
  localparam logic [31:0] LW8  = {6'd35, 5'd2, 5'd8, 16'd4};
  localparam logic [31:0] LW0  = {6'd35, 5'd2, 5'd0, 16'd4};
  localparam logic [31:0] ADD0 = {6'd0, 5'd0, 5'd0, 5'd9, 5'd0, 6'h20};
  localparam logic [31:0] ADDI = {6'd8, 5'd9, 5'd8, 16'd5};

  initial begin
    logic [5:0] ops [10] = '{6'd0, 6'd4, 6'd5, 6'd43, 6'd35, 6'd8, 6'd12, 6'd13, 6'd14, 6'd2};
    m_ctrl = 0; m_rt = 0; m_dc = 1; sc = 0; fc = 0;
    rst_n = 0; flush = 0; instr = 0; pc = 32'h4; rd1 = 0; rd2 = 0; id_ctrl = 0;
    step();
    step();
    chk("rst_ctrl", ex_ctrl, 0);
    chk("rst_rd1", ex_r1, 0);
    chk("rst_stall", stall, 0);
    chk("rst_scnt", scnt, 0);
    chk("rst_fcnt", fcnt, 0);
    rst_n = 1;
    instr = ADD; rd1 = 108; rd2 = 110; id_ctrl = 10'h021; pc = 32'h104;
    step();
    chk("pt_rd1", ex_r1, 108);
    chk("pt_rd2", ex_r2, 110);
    chk("pt_rd", ex_rd, 9);
    chk("pt_ctrl", ex_ctrl, 10'h021);
    chk("pt_stall", stall, 0);
    instr = LW8; id_ctrl = 10'h01B;
    step();
    instr = ADD; id_ctrl = 10'h021;
    #1 chk("lu_stall", stall, 1);
    step();
    chk("lu_bubble", ex_ctrl, 0);
    chk("lu_scnt", scnt, 1);
    chk("lu_release", stall, 0);
    step();
    chk("lu_add_ctrl", ex_ctrl, 10'h021);
    chk("lu_add_rd", ex_rd, 9);
    instr = LW0; id_ctrl = 10'h01B;
    step();
    instr = ADD0; id_ctrl = 10'h021;
    #1 chk("lw0_nostall", stall, 0);
    step();
    instr = LW8; id_ctrl = 10'h01B;
    step();
    instr = ADDI; id_ctrl = 10'h011;
    #1 chk("addi_nostall", stall, 0);
    step();
    instr = LW8; id_ctrl = 10'h01B;
    step();
    instr = ADD; id_ctrl = 10'h021; flush = 1;
    #1 chk("fl_stall", stall, 0);
    step();
    chk("fl_ctrl", ex_ctrl, 0);
    chk("fl_fcnt", fcnt, 1);
    chk("fl_scnt", scnt, 1);
    flush = 0;
    instr = {6'd8, 5'd1, 5'd2, 16'hFFFC}; id_ctrl = 10'h011;
    step();
    chk("sext", ex_imm, 32'hFFFF_FFFC);
    instr = {6'd13, 5'd1, 5'd2, 16'hFFFC};
    step();
    chk("zext", ex_imm, 32'h0000_FFFC);
    flush = 1;
    repeat (4) step();
    chk("sat_fcnt_w2", fcnt2, 3);
    chk("sat_fcnt", fcnt, 5);
    flush = 0;
    repeat (800) begin
      rst_n = $urandom_range(0, 59) != 0;
      flush = $urandom_range(0, 7) == 0;
      instr = {ops[$urandom_range(0, 9)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               16'($urandom)};
      id_ctrl = 10'($urandom);
      id_ctrl[1] = $urandom_range(0, 1) == 1;
      rd1 = $urandom; rd2 = $urandom; pc = $urandom;
      step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
